// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin / fixed-select multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   MAX_CH               : widest onehot vector accepted by onehot_to_idx.
//   onehot_to_idx        : OR-reduction encoder, no priority chain.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH = 32;

  // For a true onehot input this is the bit position; ORing the indices of
  // every set bit keeps it a flat OR tree instead of a priority encoder.
  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Bundle of the multiplexer's input channels and output beat.
//   mode, sel            : steering controls.
//   in_valid/in_data     : per-channel beats, channel i at [i*DATA_W +: DATA_W].
//   in_ready             : per-channel accept.
//   out_valid/out_data   : registered output beat, out_ch its source channel.
//   out_ready            : downstream accept.
// Handshake: a beat moves when valid and ready are both high at a rising
// edge; the producer holds valid and data stable until that edge.
// master = sources plus downstream sink, slave = the multiplexer.
interface rr_mux_arb_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) ();

  logic                     mode;
  logic [CH_W-1:0]          sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational round-robin arbiter.
//   req       : per-channel request.
//   ptr       : channel with highest priority this cycle.
//   en        : a granted request is actually consumed this cycle.
//   grant     : onehot grant, first request at or above ptr (wrapping).
//   grant_idx : index of the granted channel.
//   ptr_next  : pointer for the next cycle; moves past the winner only when
//               en is high and something was granted, otherwise equals ptr.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic [CH_W-1:0]   ptr_next
);

  localparam int SUM_W = CH_W + 1;

  logic [SUM_W-1:0] cand;
  logic             found;

  // Walk the channels starting at ptr; the extra bit in cand lets the
  // modulo-NUM_CH wrap work for non-power-of-two channel counts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = SUM_W'(ptr) + SUM_W'(i);
      if (cand >= SUM_W'(NUM_CH)) cand = cand - SUM_W'(NUM_CH);
      if (!found && req[cand[CH_W-1:0]]) begin
        found                  = 1'b1;
        grant[cand[CH_W-1:0]]  = 1'b1;
        grant_idx              = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (en && found) begin
      ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 multiplexer with per-channel valid/ready and one registered output
// beat. mode=0 steers by sel, mode=1 shares the output round-robin.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus        : channel inputs and output beat (rr_mux_arb_if.slave).
// A new beat loads whenever the output register is empty or being drained
// this same edge, so a held out_ready gives one beat per cycle.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_mux_arb_if.slave bus
);

  logic [NUM_CH-1:0] fixed_grant;
  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   rr_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_ptr_next;
  logic [CH_W-1:0]   grant_ch;
  logic [DATA_W-1:0] grant_data;
  logic              load;
  logic              xfer;
  logic              rr_en;

  assign load = ~bus.out_valid | bus.out_ready;

  // sel values with no matching channel leave fixed_grant empty.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fixed_grant[i] = bus.in_valid[i] & (bus.sel == CH_W'(i));
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .en        (rr_en),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .ptr_next  (rr_ptr_next)
  );

  assign grant = (bus.mode == MODE_FIXED) ? fixed_grant : rr_grant;

  // Reset gating matters: out_valid is 0 in reset, which would otherwise
  // make load=1 and advertise ready to the sources.
  assign bus.in_ready = rst_n ? (grant & {NUM_CH{load}}) : '0;
  assign xfer         = |bus.in_ready;
  assign rr_en        = rst_n & load & (bus.mode == MODE_RR);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_data = grant_data | ({DATA_W{grant[i]}} & bus.in_data[i*DATA_W +: DATA_W]);
    end
  end

  assign grant_ch = (bus.mode == MODE_RR) ? rr_idx
                                          : CH_W'(onehot_to_idx(MAX_CH'(fixed_grant)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_ch    <= grant_ch;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
module tb_rr_mux_arb;
  import mux_pkg::*;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.NUM_CH(4), .DATA_W(8)) bus ();
  rr_mux_arb_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

  rr_mux_arb #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_mux_arb #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                              input logic r, input logic [3:0] er, input logic eov,
                              input logic [7:0] ed, input logic [1:0] ec);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.ready = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_data = ed; t.exp_ch = ec;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
    bus.mode = m; bus.sel = s; bus.in_valid = v; bus.out_ready = r;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] d, input logic [1:0] c);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, "_out_data"},  32'(bus.out_data),  32'(d));
    chk({tag, "_out_ch"},    32'(bus.out_ch),    32'(c));
  endtask

  // Inputs change at posedge+1, in_ready is sampled at posedge+2 and the
  // registered outputs at the following posedge+1.
  task automatic run_vec(input vec_t v, input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    drive(v.mode, v.sel, v.valid, v.ready);
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk); #1;
    check_out(tag, v.exp_ov, v.exp_data, v.exp_ch);
  endtask

  initial begin
    logic [7:0] e;

    // Fixed select: sel=2, every channel valid.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd2));
    // Selected channel idle: no grant, output drains, data/ch hold.
    vecs.push_back(mk(1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'h20, 2'd2));
    // Round-robin fairness, pointer still 0 because fixed transfers leave it.
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0));
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd1));
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd2));
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3));
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0));
    vecs.push_back(mk(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd1));
    // Skip and wrap: only 1 and 3 valid, pointer at 2.
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd3));
      vecs.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd1));
    end
    // Single requester every cycle (pointer 2 then 3).
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd2));
    // Switch to fixed select sel=1; pointer stays 3.
    vecs.push_back(mk(1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd1));

    // ---------------- reset with toggling inputs ----------------
    bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
    bus3.in_data = {8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = 2'($urandom_range(0, 3));
      bus.in_valid  = 4'($urandom_range(1, 15));
      bus.in_data   = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus3.in_valid = 3'($urandom_range(1, 7));
      @(negedge clk);
      check_out($sformatf("rst%0d", i), 1'b0, 8'h00, 2'd0);
      chk($sformatf("rst%0d_in_ready", i), 32'(bus.in_ready), 32'h0);
      chk($sformatf("rst%0d_n3_in_ready", i), 32'(bus3.in_ready), 32'h0);
    end
    bus.in_data = {8'h30, 8'h20, 8'h10, 8'h00};
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    bus3.in_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- 3-channel instance: out-of-range sel, wrap ----------------
    bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    #1 chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'h0);
    @(posedge clk); #1;
    chk("n3_sel3_out_valid", 32'(bus3.out_valid), 32'h0);
    bus3.mode = 1'b1; bus3.in_valid = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("n3_rr%0d_in_ready", i), 32'(bus3.in_ready), (i == 1) ? 32'h4 : 32'h1);
      @(posedge clk); #1;
      chk($sformatf("n3_rr%0d_out_ch", i), 32'(bus3.out_ch), (i == 1) ? 32'h2 : 32'h0);
      chk($sformatf("n3_rr%0d_out_data", i), 32'(bus3.out_data), (i == 1) ? 32'h22 : 32'h00);
    end
    bus3.in_valid = '0;

    // ---------------- table-driven vectors ----------------
    foreach (vecs[k]) run_vec(vecs[k], k);

    // ---------------- backpressure: hold 0x10 from channel 1 ----------------
    drive(1'b1, 2'd0, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'h0);
      @(posedge clk); #1;
      check_out($sformatf("bp%0d", i), 1'b1, 8'h10, 2'd1);
    end
    // Release: the held beat leaves and the pointer (3) resumes the rotation.
    bus.out_ready = 1'b1;
    #1 chk("rel_in_ready", 32'(bus.in_ready), 32'h8);
    exp_q = {8'h30, 8'h00, 8'h10, 8'h20};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_out($sformatf("rel%0d", i), 1'b1, e, e[5:4]);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    #3 rst_n = 1'b0;
    #1;
    check_out("mrst", 1'b0, 8'h00, 2'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;
    check_out("post_rst", 1'b1, 8'h00, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
